// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Definitions shared between the tx block and its upstream feeder tx_ingress:
// data and threshold widths, the ingress FSM state encoding and the default
// length of the init pulse.
// ---------------------------------------------------------------------------
package tx_pkg;

    // Word width of DATA_IN_TX on the tx main FIFO
    localparam int DATA_W = 6;

    // Width of the tx almost-full threshold latched on init
    localparam int THRESH_W = 5;

    // Default number of cycles the init pulse is held high
    localparam int INIT_CYCLES_DEF = 2;

    // Ingress sequencing FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage : tx_pkg

// File: rtl/tx_ingress_fifo.sv
// ---------------------------------------------------------------------------
// tx_ingress_fifo
// Small synchronous skid FIFO, DEPTH x DATA_W, with no bypass path: a word
// written on one edge becomes visible at head right after that edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      write strobe and word (ignored while full)
//   rd_en               pop strobe (ignored while empty)
//   head                word at the read pointer
//   occupancy           number of stored words, 0..DEPTH
//   full, empty         occupancy == DEPTH / occupancy == 0
// ---------------------------------------------------------------------------
module tx_ingress_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 6,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       occupancy,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       occ_r;
    logic              wr_ok_s;
    logic              rd_ok_s;

    // Strobes are qualified locally so a misbehaving caller cannot corrupt occupancy
    always_comb begin
        wr_ok_s = wr_en && (occ_r != OCC_FULL);
        rd_ok_s = rd_en && (occ_r != '0);
    end

    // Storage, pointers and occupancy; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign occupancy = occ_r;
    assign full      = (occ_r == OCC_FULL);
    assign empty     = (occ_r == '0);

endmodule : tx_ingress_fifo

// File: rtl/tx_ingress.sv
// ---------------------------------------------------------------------------
// tx_ingress
// Upstream feeder for tx. Buffers host words in a skid FIFO, pushes them into
// the tx main FIFO while honouring MAIN_PAUSE, sequences the tx init pulse and
// keeps push/stall statistics.
// Ports:
//   clk, RESET_L              clock, asynchronous active-low reset
//   start                     level request for the init sequence
//   host_valid/host_data      host word offer
//   host_ready                skid FIFO can take a word (decoded from registers)
//   MAIN_PAUSE                almost-full backpressure from tx
//   PUSH_MAIN/DATA_IN_TX      registered push strobe and word to tx
//   init                      registered init/threshold-latch pulse to tx
//   running                   registered, high while in RUN
//   push_count                words pushed to tx, wraps
//   pause_count               stalled RUN cycles, saturates
// ---------------------------------------------------------------------------
module tx_ingress
    import tx_pkg::*;
#(
    parameter int DATA_W      = tx_pkg::DATA_W,
    parameter int DEPTH       = 4,
    parameter int INIT_CYCLES = tx_pkg::INIT_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              MAIN_PAUSE,
    output logic              PUSH_MAIN,
    output logic [DATA_W-1:0] DATA_IN_TX,
    output logic              init,
    output logic              running,
    output logic [CNT_W-1:0]  push_count,
    output logic [CNT_W-1:0]  pause_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0]  INIT_LAST = ICW'(INIT_CYCLES - 1);
    localparam logic [ICW-1:0]  INIT_ONE  = ICW'(1);
    localparam logic [AW:0]     OCC_DEPTH = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [ICW-1:0]     init_cnt_r;

    logic [DATA_W-1:0]  fifo_head_s;
    logic [AW:0]        fifo_occ_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               host_ready_s;
    logic               wr_en_s;
    logic               pop_s;
    logic               stall_s;

    logic               push_main_r;
    logic [DATA_W-1:0]  data_r;
    logic               init_r;
    logic               running_r;
    logic [CNT_W-1:0]   push_count_r;
    logic [CNT_W-1:0]   pause_count_r;

    logic               push_main_nxt_s;
    logic [DATA_W-1:0]  data_nxt_s;
    logic               init_nxt_s;
    logic               running_nxt_s;
    logic [CNT_W-1:0]   push_count_nxt_s;
    logic [CNT_W-1:0]   pause_count_nxt_s;

    // Host-side handshake and pop decision, all decoded from registered state.
    // Occupancy and the full flag are both required to allow a write so that a
    // single corrupted register cannot open the write port on a full FIFO.
    always_comb begin
        host_ready_s = (state_r != IDLE) && (fifo_occ_s < OCC_DEPTH) && !fifo_full_s;
        wr_en_s      = host_valid && host_ready_s;
        pop_s        = (state_r == RUN) && !fifo_empty_s && !MAIN_PAUSE;
        stall_s      = (state_r == RUN) && !fifo_empty_s && MAIN_PAUSE;
    end

    tx_ingress_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (RESET_L),
        .wr_en     (wr_en_s),
        .wr_data   (host_data),
        .rd_en     (pop_s),
        .head      (fifo_head_s),
        .occupancy (fifo_occ_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // State register and init-length counter
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r    <= IDLE;
            init_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == INIT) && (state_nxt_s == INIT)) begin
                init_cnt_r <= init_cnt_r + INIT_ONE;
            end else begin
                init_cnt_r <= '0;
            end
        end
    end

    // Next-state logic; re-init from RUN waits until nothing is buffered or in flight
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = INIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                if (start && fifo_empty_s && !push_main_r) begin
                    state_nxt_s = INIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; init/running follow the next state
    always_comb begin
        push_main_nxt_s   = pop_s;
        data_nxt_s        = data_r;
        init_nxt_s        = (state_nxt_s == INIT);
        running_nxt_s     = (state_nxt_s == RUN);
        push_count_nxt_s  = push_count_r;
        pause_count_nxt_s = pause_count_r;
        if (pop_s) begin
            data_nxt_s = fifo_head_s;
        end else begin
            data_nxt_s = data_r;
        end
        if (push_main_r) begin
            push_count_nxt_s = push_count_r + CNT_ONE;
        end else begin
            push_count_nxt_s = push_count_r;
        end
        if (stall_s && !(&pause_count_r)) begin
            pause_count_nxt_s = pause_count_r + CNT_ONE;
        end else begin
            pause_count_nxt_s = pause_count_r;
        end
    end

    // Output and statistics registers
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            push_main_r   <= 1'b0;
            data_r        <= '0;
            init_r        <= 1'b0;
            running_r     <= 1'b0;
            push_count_r  <= '0;
            pause_count_r <= '0;
        end else begin
            push_main_r   <= push_main_nxt_s;
            data_r        <= data_nxt_s;
            init_r        <= init_nxt_s;
            running_r     <= running_nxt_s;
            push_count_r  <= push_count_nxt_s;
            pause_count_r <= pause_count_nxt_s;
        end
    end

    assign host_ready  = host_ready_s;
    assign PUSH_MAIN   = push_main_r;
    assign DATA_IN_TX  = data_r;
    assign init        = init_r;
    assign running     = running_r;
    assign push_count  = push_count_r;
    assign pause_count = pause_count_r;

endmodule : tx_ingress

// File: tb/tb_tx_ingress.sv
// ---------------------------------------------------------------------------
// tb_tx_ingress
// Directed bench for tx_ingress with hand-computed expectations. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_tx_ingress;

    logic        clk;
    logic        RESET_L;
    logic        start;
    logic        host_valid;
    logic [5:0]  host_data;
    logic        host_ready;
    logic        MAIN_PAUSE;
    logic        PUSH_MAIN;
    logic [5:0]  DATA_IN_TX;
    logic        init;
    logic        running;
    logic [15:0] push_count;
    logic [15:0] pause_count;

    int n_checks;
    int n_errors;

    tx_ingress dut (
        .clk         (clk),
        .RESET_L     (RESET_L),
        .start       (start),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .MAIN_PAUSE  (MAIN_PAUSE),
        .PUSH_MAIN   (PUSH_MAIN),
        .DATA_IN_TX  (DATA_IN_TX),
        .init        (init),
        .running     (running),
        .push_count  (push_count),
        .pause_count (pause_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic push, input logic ini,
                           input logic run, input logic rdy);
        chk({tag, ".push"},    32'(PUSH_MAIN),  32'(push));
        chk({tag, ".init"},    32'(init),       32'(ini));
        chk({tag, ".running"}, 32'(running),    32'(run));
        chk({tag, ".ready"},   32'(host_ready), 32'(rdy));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        RESET_L    = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        host_data  = 6'd0;
        MAIN_PAUSE = 1'b0;

        // Reset values
        #3;
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.data",  32'(DATA_IN_TX),  32'd0);
        chk("rst.pcnt",  32'(push_count),  32'd0);
        chk("rst.scnt",  32'(pause_count), 32'd0);
        #4;
        RESET_L = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_ctl("idle5", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle5.pcnt", 32'(push_count), 32'd0);

        // Init sequence: one-cycle start request
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("init1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctl("init2", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctl("run0", 1'b0, 1'b0, 1'b1, 1'b1);

        // Stream 0x01..0x04 back-to-back with no backpressure
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = 6'(i + 1);
            tick();
            chk($sformatf("strm%0d.push", i), 32'(PUSH_MAIN), (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) chk($sformatf("strm%0d.data", i), 32'(DATA_IN_TX), 32'(i));
        end
        host_valid = 1'b0;
        tick();
        chk("strm4.push", 32'(PUSH_MAIN),  32'd1);
        chk("strm4.data", 32'(DATA_IN_TX), 32'h04);
        tick();
        chk("strm.end.push", 32'(PUSH_MAIN),  32'd0);
        chk("strm.end.data", 32'(DATA_IN_TX), 32'h04);
        chk("strm.pcnt",     32'(push_count), 32'd4);

        // Backpressure: preload to full while paused
        MAIN_PAUSE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = 6'(8'h11 + i);
            tick();
        end
        chk("bp.full.ready", 32'(host_ready),  32'd0);
        chk("bp.full.scnt",  32'(pause_count), 32'd3);
        host_data = 6'h3F;
        for (int i = 0; i < 3; i++) tick();
        chk_ctl("bp.hold", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp.hold.scnt", 32'(pause_count), 32'd6);
        MAIN_PAUSE = 1'b0;
        host_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bp.rel%0d.push", i), 32'(PUSH_MAIN),  32'd1);
            chk($sformatf("bp.rel%0d.data", i), 32'(DATA_IN_TX), 32'(8'h11 + i));
        end
        chk("bp.rel.scnt", 32'(pause_count), 32'd6);
        tick();
        chk("bp.end.push", 32'(PUSH_MAIN),  32'd0);
        chk("bp.end.pcnt", 32'(push_count), 32'd8);

        // Mid-transfer asynchronous reset
        MAIN_PAUSE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = 6'(8'h21 + i);
            tick();
        end
        host_valid = 1'b0;
        MAIN_PAUSE = 1'b0;
        tick();
        tick();
        chk("mr.pre.data", 32'(DATA_IN_TX), 32'h22);
        #2;
        RESET_L = 1'b0;
        #1;
        chk_ctl("mr.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mr.async.data", 32'(DATA_IN_TX),  32'd0);
        chk("mr.async.pcnt", 32'(push_count),  32'd0);
        chk("mr.async.scnt", 32'(pause_count), 32'd0);
        #1;
        RESET_L = 1'b1;
        tick();
        chk_ctl("mr.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_ctl("mr.run", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("mr.flushed0", 32'(PUSH_MAIN), 32'd0);
        tick();
        chk("mr.flushed1", 32'(PUSH_MAIN), 32'd0);

        // Re-init guard: start held while words are buffered and paused
        MAIN_PAUSE = 1'b1;
        host_valid = 1'b1;
        host_data  = 6'h31;
        tick();
        host_data  = 6'h32;
        tick();
        host_valid = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl($sformatf("grd%0d", i), 1'b0, 1'b0, 1'b1, 1'b1);
        end
        MAIN_PAUSE = 1'b0;
        tick();
        chk("grd.p0.push", 32'(PUSH_MAIN),  32'd1);
        chk("grd.p0.data", 32'(DATA_IN_TX), 32'h31);
        chk("grd.p0.init", 32'(init),       32'd0);
        tick();
        chk("grd.p1.push", 32'(PUSH_MAIN),  32'd1);
        chk("grd.p1.data", 32'(DATA_IN_TX), 32'h32);
        chk("grd.p1.init", 32'(init),       32'd0);
        tick();
        chk_ctl("grd.drain", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        chk_ctl("grd.init1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctl("grd.init2", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctl("grd.run", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("grd.pcnt", 32'(push_count),  32'd2);
        chk("grd.scnt", 32'(pause_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tx_ingress
